// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary helpers for the asynchronous FIFO pointer
// controllers (write side now, read side later).
package fifo_pkg;

  // Default RAM address width; FIFO depth is 2**ADDR_SIZE.
  localparam int DEF_ADDR_SIZE = 4;

  // Widest pointer any controller may use (ADDR_SIZE up to 16, plus wrap bit).
  localparam int MAX_PTR_W = 17;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  // Number of RAM entries for a given address width.
  function automatic int depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Binary to reflected Gray; narrower pointers are zero-extended by the
  // caller and truncated back, which leaves the result unchanged.
  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray to binary, MSB-first running XOR.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary decoder of parametrised width. Used to
// decode the synchronised opposite-domain pointer in both FIFO controllers.
module gray2bin_conv #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and status controller for the asynchronous FIFO.
// Keeps binary/Gray write pointers, a registered full flag, fill level and
// programmable almost-full flag. Defining WPTR_OVF_ERR_EN adds a sticky
// overflow-error flag (wovf) with its clear input (wovf_clr).
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int AFULL_LEVEL = depth(ADDR_SIZE) - 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 wafull,
  output logic [ADDR_SIZE:0]   wlevel
`ifdef WPTR_OVF_ERR_EN
  ,
  input  logic                 wovf_clr,
  output logic                 wovf
`endif
);

  typedef logic [ADDR_SIZE:0] ptr_t;

  // Almost-full threshold at pointer width; AFULL_LEVEL never exceeds depth,
  // so it always fits in ADDR_SIZE+1 bits.
  localparam ptr_t AFULL_THR = ptr_t'(AFULL_LEVEL);

  ptr_t wbin;
  ptr_t wbin_next;
  ptr_t wgray_next;
  ptr_t rbin;
  ptr_t rptr_full_cmp;
  ptr_t wlevel_next;
  logic wen;
  logic wfull_next;
  logic wafull_next;

  // Decode the synchronised read pointer for the level subtraction.
  gray2bin_conv #(
    .WIDTH(ADDR_SIZE + 1)
  ) u_rptr_dec (
    .gray(wq2_rptr),
    .bin (rbin)
  );

  // Next-state pointer, full, level and almost-full terms.
  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every pass, so no latch can be inferred.
  always_comb begin
    wen           = winc & ~wfull;
    wbin_next     = wbin + ptr_t'(wen);
    wgray_next    = ptr_t'(bin2gray(ptr_max_t'(wbin_next)));
    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the top two bits inverted.
    rptr_full_cmp = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
    wfull_next    = (wgray_next == rptr_full_cmp);
    // The read pointer lags, so this difference can only overstate the fill.
    wlevel_next   = wbin_next - rbin;
    wafull_next   = (wlevel_next >= AFULL_THR);
  end

  // Pointer and status registers; all cleared by the asynchronous reset.
  // NOTE: sequential state is updated with non-blocking '<=' so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
    end else begin
      wbin   <= wbin_next;
      wptr   <= wgray_next;
      wfull  <= wfull_next;
      wafull <= wafull_next;
      wlevel <= wlevel_next;
    end
  end

  // RAM write address is a plain slice of the binary pointer register.
  assign waddr = wbin[ADDR_SIZE-1:0];

`ifdef WPTR_OVF_ERR_EN
  // Sticky overflow error: set by a write attempted while full; a clear in
  // the same cycle as a set loses.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl. Expected outputs come from a small
// integer model and flow through a scoreboard queue. Build with
// WPTR_OVF_ERR_EN defined to also exercise the overflow flag.
module tb_wptr_full_ctrl;

  localparam int AW      = 4;
  localparam int DEPTH   = 1 << AW;
  localparam int PTR_MOD = 1 << (AW + 1);
  localparam int AFULL   = DEPTH - 2;

  typedef logic [AW:0] ptr_t;

  typedef struct packed {
    ptr_t          wptr;
    logic [AW-1:0] waddr;
    logic          wfull;
    logic          wafull;
    ptr_t          wlevel;
    logic          wovf;
  } exp_t;

  logic          wclk;
  logic          wrst_n;
  logic          winc;
  ptr_t          wq2_rptr;
  logic [AW-1:0] waddr;
  ptr_t          wptr;
  logic          wfull;
  logic          wafull;
  ptr_t          wlevel;
  logic          wovf_clr;
`ifdef WPTR_OVF_ERR_EN
  logic          wovf;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   n_edges = 0;
  exp_t sb[$];

  // Reference model state.
  int   m_bin;
  logic m_full;
  logic m_ovf;
  ptr_t prev_wptr;

  wptr_full_ctrl #(
    .ADDR_SIZE  (AW),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .winc    (winc),
    .wq2_rptr(wq2_rptr),
    .waddr   (waddr),
    .wptr    (wptr),
    .wfull   (wfull),
    .wafull  (wafull),
    .wlevel  (wlevel)
`ifdef WPTR_OVF_ERR_EN
    ,
    .wovf_clr(wovf_clr),
    .wovf    (wovf)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(posedge wclk) n_edges++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input ptr_t g);
    int   b = 0;
    logic p = 1'b0;
    for (int i = AW; i >= 0; i--) begin
      p = p ^ g[i];
      if (p) b = b | (1 << i);
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bin  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":wptr"},   32'(wptr),   32'd0);
    check({tag, ":waddr"},  32'(waddr),  32'd0);
    check({tag, ":wfull"},  32'(wfull),  32'd0);
    check({tag, ":wafull"}, 32'(wafull), 32'd0);
    check({tag, ":wlevel"}, 32'(wlevel), 32'd0);
`ifdef WPTR_OVF_ERR_EN
    check({tag, ":wovf"},   32'(wovf),   32'd0);
`endif
  endtask

  // One clock of stimulus: drive at the falling edge, predict, push; then
  // pop and compare just after the rising edge.
  task automatic step(input logic inc, input ptr_t rptr, input logic clr, input string tag);
    exp_t e;
    int   lvl;
    logic acc;
    @(negedge wclk);
    winc      = inc;
    wq2_rptr  = rptr;
    wovf_clr  = clr;
    prev_wptr = wptr;
    acc = inc && !m_full;
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    if (acc) m_bin = (m_bin + 1) % PTR_MOD;
    lvl    = (m_bin - from_gray(rptr) + PTR_MOD) % PTR_MOD;
    m_full = (lvl == DEPTH);
    e.wptr   = ptr_t'(to_gray(m_bin));
    e.waddr  = (AW)'(m_bin % DEPTH);
    e.wfull  = m_full;
    e.wafull = (lvl >= AFULL);
    e.wlevel = ptr_t'(lvl);
    e.wovf   = m_ovf;
    sb.push_back(e);
    @(posedge wclk);
    #1;
    e = sb.pop_front();
    check({tag, ":wptr"},   32'(wptr),   32'(e.wptr));
    check({tag, ":waddr"},  32'(waddr),  32'(e.waddr));
    check({tag, ":wfull"},  32'(wfull),  32'(e.wfull));
    check({tag, ":wafull"}, 32'(wafull), 32'(e.wafull));
    check({tag, ":wlevel"}, 32'(wlevel), 32'(e.wlevel));
`ifdef WPTR_OVF_ERR_EN
    check({tag, ":wovf"},   32'(wovf),   32'(e.wovf));
`endif
  endtask

  initial begin
    int   e0;
    logic saw_wrap;
    ptr_t held;

    // Reset held with winc active: outputs must stay at zero.
    wrst_n   = 1'b0;
    winc     = 1'b1;
    wq2_rptr = '0;
    wovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    check_zero("in_reset");
    @(negedge wclk);
    winc = 1'b0;
    #1;
    wrst_n = 1'b1;
    #1;
    check_zero("after_release");

    // Fill from empty with the read pointer parked at zero.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, '0, 1'b0, "fill");
      if (i == AFULL) begin
        check("fill14:wafull", 32'(wafull), 32'd1);
        check("fill14:wlevel", 32'(wlevel), 32'd14);
      end
    end
    check("fill16:wfull",  32'(wfull),  32'd1);
    check("fill16:wlevel", 32'(wlevel), 32'd16);
    check("fill16:wptr",   32'(wptr),   32'b11000);
    check("fill16:waddr",  32'(waddr),  32'd0);

    // Writes while full are dropped.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, '0, 1'b0, "wr_full");
      check("wr_full:wptr_held",  32'(wptr),  32'b11000);
      check("wr_full:waddr_held", 32'(waddr), 32'd0);
`ifdef WPTR_OVF_ERR_EN
      check("wr_full:wovf_set", 32'(wovf), 32'd1);
`endif
    end
    step(1'b1, '0, 1'b1, "ovf_set_wins");
    step(1'b0, '0, 1'b1, "ovf_clr");
`ifdef WPTR_OVF_ERR_EN
    check("ovf_clr:wovf", 32'(wovf), 32'd0);
`endif

    // Read pointer advances by one: full releases next edge.
    step(1'b0, 5'b00001, 1'b0, "release");
    check("release:wfull",  32'(wfull),  32'd0);
    check("release:wlevel", 32'(wlevel), 32'd15);
    check("release:wafull", 32'(wafull), 32'd1);

    // Drain to level 2, then 40 writes with the reader two behind.
    step(1'b0, ptr_t'(to_gray(14)), 1'b0, "drain");
    saw_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, ptr_t'(to_gray((m_bin + 1 - 2 + PTR_MOD) % PTR_MOD)), 1'b0, "wrap");
      check("wrap:level2", 32'(wlevel), 32'd2);
      check("wrap:gray_1bit", 32'($countones(wptr ^ prev_wptr)), 32'd1);
      if (m_bin == 0) begin
        saw_wrap = 1'b1;
        check("wrap:wptr_before", 32'(prev_wptr), 32'b10000);
        check("wrap:wptr_after",  32'(wptr),      32'd0);
      end
    end
    check("wrap:seen", 32'(saw_wrap), 32'd1);

    // Refill, then advance the reader in the same cycle as a refused write.
    held = wq2_rptr;
    for (int i = 0; i < DEPTH - 2; i++) step(1'b1, held, 1'b0, "refill");
    check("refill:wfull", 32'(wfull), 32'd1);
    held = ptr_t'(to_gray((from_gray(held) + 1) % PTR_MOD));
    step(1'b1, held, 1'b0, "simul");
    check("simul:refused", 32'(wptr === prev_wptr), 32'd1);
    check("simul:wfull",   32'(wfull),  32'd0);
    check("simul:wlevel",  32'(wlevel), 32'd15);
    step(1'b1, held, 1'b0, "after_simul");
    check("after_simul:accepted", 32'(wptr !== prev_wptr), 32'd1);
    check("after_simul:wfull",    32'(wfull), 32'd1);

    // Asynchronous reset in the middle of a clock high phase at level 9.
    @(negedge wclk);
    winc   = 1'b0;
    wrst_n = 1'b0;
    #1;
    wrst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) step(1'b1, '0, 1'b0, "pre_rst");
    check("pre_rst:wlevel", 32'(wlevel), 32'd9);
    #2;
    e0 = n_edges;
    wrst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    check("mid_rst:no_edge", 32'(n_edges), 32'(e0));
    model_reset();
    @(negedge wclk);
    winc = 1'b0;
    #2;
    wrst_n = 1'b1;
    #1;
    check_zero("mid_rst_release");
    step(1'b1, '0, 1'b0, "post_rst");
    check("post_rst:wlevel", 32'(wlevel), 32'd1);

    winc = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and status controller for the asynchronous FIFO. It is the parametrised successor of the basic write-pointer/full block. It keeps the binary and Gray write pointers and compares them against the synchronised Gray read pointer to produce a registered full flag. It also adds a registered fill level, a programmable almost-full flag and an optional sticky overflow-error flag. It sits in the wclk domain between the write client, the dual-port RAM write address, and the read-to-write pointer synchroniser.

## Interface
Parameters:
- ADDR_SIZE, 4, RAM address width; depth = 2^ADDR_SIZE; legal range 2..16
- AFULL_LEVEL, (1<<ADDR_SIZE)-2, fill level at or above which wafull asserts; legal range 1..2^ADDR_SIZE

Ports (one clock, wclk; reset wrst_n is asynchronous, active-low):
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- winc  in  1  write request from the client
- wq2_rptr  in  ADDR_SIZE+1  Gray read pointer, already synchronised to wclk
- waddr  out  ADDR_SIZE  RAM write address; equals wbin[ADDR_SIZE-1:0]
- wptr  out  ADDR_SIZE+1  registered Gray write pointer, sent to the read-domain synchroniser
- wfull  out  1  registered full flag
- wafull  out  1  registered almost-full flag
- wlevel  out  ADDR_SIZE+1  registered fill level, 0..2^ADDR_SIZE
- wovf_clr  in  1  clears wovf (present only with WPTR_OVF_ERR_EN)
- wovf  out  1  sticky overflow error (present only with WPTR_OVF_ERR_EN)

## Operation
- Write acceptance: wen = winc & ~wfull.
- Next pointers:
  - wbin_next = wbin + wen, computed mod 2^(ADDR_SIZE+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
- Pointer registers: wbin and wptr load wbin_next and wgray_next on every wclk edge.
- Full:
  - wfull_next = (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
  - wfull is registered from wfull_next.
- Level:
  - rbin = Gray-to-binary of wq2_rptr.
  - wlevel_next = (wbin_next - rbin), computed mod 2^(ADDR_SIZE+1).
  - wlevel is registered from wlevel_next.
- Almost-full: wafull is registered from (wlevel_next >= AFULL_LEVEL). wafull is always 1 whenever wfull is 1.
- Write while full (winc=1, wfull=1): the write is dropped. wbin, wptr and waddr are unchanged.
- Level is conservative: wq2_rptr lags by the synchroniser delay, so wlevel and wfull may overstate occupancy, never understate it.
- Wrap-around: wbin wraps from 2^(ADDR_SIZE+1)-1 to 0 with no special handling. The Gray pointer changes by exactly one bit per accepted write.
- Reset: the following outputs are 0 while wrst_n=0 and immediately after release:
  - wbin, wptr, waddr
  - wfull, wafull, wlevel
  - wovf
- Reset mid-operation: assertion clears all state asynchronously, regardless of winc.

## Timing
- Accepted write: wptr, waddr and wlevel update at the same wclk edge that samples winc=1.
- Full set: wfull asserts at the edge that accepts the write filling the last slot. A winc in the following cycle is refused.
- Full release: wfull deasserts at the first wclk edge after a changed wq2_rptr is presented. Latency is one wclk cycle from the wq2_rptr input.
- Simultaneous events: if winc=1 and wfull=1 while wq2_rptr advances in the same cycle, the write is still refused (wfull is the registered value). wfull then deasserts at that edge.
- Combinational paths: there are no combinational paths from any input to any output. waddr is a direct slice of a register.

## Configuration
- Macro: WPTR_OVF_ERR_EN.
- With the macro defined:
  - wovf_clr and wovf exist.
  - wovf sets at the edge that samples winc=1 & wfull=1.
  - wovf clears at the edge that samples wovf_clr=1, unless a set occurs in the same cycle; set wins.
- Without the macro: both ports are absent, and refused writes are silently dropped.

## Structure
- Package fifo_pkg holds:
  - the default ADDR_SIZE constant
  - a parametrised Gray/binary conversion function pair (bin2gray, gray2bin)
  - a localparam-style DEPTH helper
- Sub-module gray2bin_conv (parametrised width, purely combinational) is instantiated once to decode wq2_rptr. The same sub-module is reused by the future read-side controller.

## Test plan
- Reset fill, defaults, wq2_rptr=0: 16 consecutive winc. Required response:
  - after the 14th write: wafull=1, wlevel=14
  - after the 16th write: wfull=1, wlevel=16, wbin=16, wptr=5'b11000, waddr=0
- Write when full: 3 further winc pulses. Required response:
  - wptr stays 5'b11000 and waddr stays 0
  - with WPTR_OVF_ERR_EN: wovf=1 after the first pulse, remaining 1 until a wovf_clr pulse, then 0
- Full release: drive wq2_rptr=5'b00001 (Gray 1). Required response at the next edge: wfull=0, wlevel=15, wafull=1.
- Wrap-around: 40 writes with wq2_rptr tracking 2 writes behind. Required response:
  - wbin passes 31→0, with wptr 5'b10000→5'b00000
  - wfull never asserts
  - wlevel stays 2
- Simultaneous events: hold wfull=1 and winc=1 while wq2_rptr advances by one. Required response:
  - that cycle's write is refused
  - wfull drops at that edge
  - the next winc is accepted
- Mid-operation reset: assert wrst_n=0 asynchronously mid-cycle at wlevel=9. Required response: all outputs read 0 immediately, before the next wclk edge.
